// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
// Response ownership travels one cycle behind the read grant.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } resp_owner_t;

    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/starve_counter.sv
// Saturating up-counter of consecutive denied fetch cycles.
// Clear has priority over increment; o_sat flags the priority threshold.
module starve_counter #(
    parameter int LIMIT = 4,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic nrst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_sat
);

    logic [W-1:0] r_cnt;
    logic         w_sat;

    assign w_sat = (r_cnt == W'(LIMIT));
    assign o_sat = w_sat;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one sync-read memory between fetch (read-only) and data (read/write).
// Data reads win unless fetch has starved; writes use the separate write port.
//
// resp_owner | meaning
// NONE       | no read issued last cycle
// FETCH      | mem_rdata this cycle belongs to fetch
// DATA       | mem_rdata this cycle belongs to the data stage
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    input  logic        f_flush,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen
);

    resp_owner_t r_resp_owner;
    resp_owner_t w_resp_next;

    logic w_f_live;
    logic w_d_rd;
    logic w_d_wr;
    logic w_fetch_pri;
    logic w_d_rd_gnt;
    logic w_f_gnt;

    assign w_f_live = f_req & ~f_flush;
    assign w_d_rd   = d_req & ~d_we;
    assign w_d_wr   = d_req & d_we;

    assign w_d_rd_gnt = w_d_rd & ~(w_f_live & w_fetch_pri);
    assign w_f_gnt    = w_f_live & ~w_d_rd_gnt;

    assign f_gnt = w_f_gnt;
    assign d_gnt = w_d_wr | w_d_rd_gnt;

    assign mem_raddr = w_d_rd_gnt ? d_addr : f_addr;
    assign mem_waddr = d_addr;
    assign mem_wdata = d_wdata;
    // Gate with reset so no stray write lands while the block is held in reset.
    assign mem_wen   = w_d_wr & nrst;

    starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .W     (CNT_W)
    ) u_starve (
        .clk   (clk),
        .nrst  (nrst),
        .i_clr (w_f_gnt | ~f_req | f_flush),
        .i_inc (f_req & ~w_f_gnt),
        .o_sat (w_fetch_pri)
    );

    always_comb begin
        w_resp_next = NONE;
        if (w_d_rd_gnt) begin
            w_resp_next = DATA;
        end else if (w_f_gnt) begin
            w_resp_next = FETCH;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_resp_owner <= NONE;
        end else begin
            r_resp_owner <= w_resp_next;
        end
    end

    assign f_rvalid = (r_resp_owner == FETCH) & ~f_flush;
    assign d_rvalid = (r_resp_owner == DATA);
    assign f_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against
// a cycle-level reference model and a local synchronous memory.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        nrst;
    logic        f_req, f_flush, d_req, d_we;
    logic [31:0] f_addr, d_addr, d_wdata;
    logic        f_gnt, f_rvalid, d_gnt, d_rvalid, mem_wen;
    logic [31:0] f_rdata, d_rdata, mem_raddr, mem_rdata, mem_waddr, mem_wdata;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_flush   (f_flush),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    always @(posedge clk) begin
        mem_rdata <= mem[mem_raddr[7:0]];
        if (mem_wen) mem[mem_waddr[7:0]] <= mem_wdata;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: waiting-cycle count, owner of next response, expected data.
    logic [31:0] ref_mem [256];
    int          m_wait;
    int          m_owner;   // 0 none, 1 fetch, 2 data
    logic [31:0] m_data;
    logic        last_fgnt, last_dgnt;

    task automatic step(input logic freq, input logic [31:0] faddr, input logic fflush,
                        input logic dreq, input logic dwe, input logic [31:0] daddr,
                        input logic [31:0] dwdata);
        bit fetch_wants, data_reads, data_writes, data_rd_wins, fetch_wins;
        @(negedge clk);
        f_req = freq; f_addr = faddr; f_flush = fflush;
        d_req = dreq; d_we = dwe; d_addr = daddr; d_wdata = dwdata;
        #1;
        fetch_wants  = freq && !fflush;
        data_reads   = dreq && !dwe;
        data_writes  = dreq && dwe;
        data_rd_wins = data_reads && !(fetch_wants && m_wait >= LIMIT);
        fetch_wins   = fetch_wants && !data_rd_wins;

        chk("f_rvalid", f_rvalid, (m_owner == 1) && !fflush);
        chk("d_rvalid", d_rvalid, m_owner == 2);
        if (m_owner == 1 && !fflush) chk("f_rdata", f_rdata, m_data);
        if (m_owner == 2) chk("d_rdata", d_rdata, m_data);
        chk("f_gnt", f_gnt, fetch_wins);
        chk("d_gnt", d_gnt, data_writes || data_rd_wins);
        chk("mem_wen", mem_wen, data_writes);
        if (data_writes) begin
            chk("mem_waddr", mem_waddr, daddr);
            chk("mem_wdata", mem_wdata, dwdata);
        end
        if (data_rd_wins) chk("mem_raddr_d", mem_raddr, daddr);
        else if (fetch_wins) chk("mem_raddr_f", mem_raddr, faddr);
        last_fgnt = f_gnt;
        last_dgnt = d_gnt;

        if (data_rd_wins) begin
            m_owner = 2; m_data = ref_mem[daddr[7:0]];
        end else if (fetch_wins) begin
            m_owner = 1; m_data = ref_mem[faddr[7:0]];
        end else begin
            m_owner = 0;
        end
        if (data_writes) ref_mem[daddr[7:0]] = dwdata;
        if (!freq || fflush || fetch_wins) m_wait = 0;
        else if (m_wait < LIMIT) m_wait++;
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        int first_fgnt, n_fgnt;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'hA0 + i;
            ref_mem[i] = 32'hA0 + i;
        end
        m_wait = 0; m_owner = 0; m_data = '0;
        nrst = 1'b0;
        f_req = 0; f_addr = 0; f_flush = 0;
        d_req = 1; d_we = 1; d_addr = 0; d_wdata = 0;
        #12;
        chk("rst_f_rvalid", f_rvalid, 1'b0);
        chk("rst_d_rvalid", d_rvalid, 1'b0);
        chk("rst_mem_wen", mem_wen, 1'b0);
        d_req = 0; d_we = 0;
        @(negedge clk);
        nrst = 1'b1;

        // Fetch-only stream
        for (int a = 0; a < 3; a++) step(1, a, 0, 0, 0, 0, 0);
        idle();

        // Contention: data read wins by default
        step(1, 32'h20, 0, 1, 0, 32'h10, 0);
        chk("cont_dgnt", last_dgnt, 1'b1);
        chk("cont_fgnt", last_fgnt, 1'b0);
        idle();

        // Starvation: continuous data reads with fetch held
        first_fgnt = -1; n_fgnt = 0;
        for (int c = 0; c < 10; c++) begin
            step(1, 32'h40 + c, 0, 1, 0, 32'h50 + c, 0);
            if (last_fgnt) begin
                n_fgnt++;
                if (first_fgnt < 0) first_fgnt = c;
            end
        end
        chk("starve_first", first_fgnt, 4);
        chk("starve_count", n_fgnt, 2);
        idle();

        // Write alongside fetch, then read back
        step(1, 32'd3, 0, 1, 1, 32'd7, 32'hDEAD);
        chk("wr_f_both", last_fgnt & last_dgnt, 1'b1);
        step(0, 0, 0, 1, 0, 32'd7, 0);
        idle();
        chk("wr_readback", ref_mem[7], 32'hDEAD);

        // Flush in the response cycle, then starvation restarts from zero
        step(1, 32'd5, 0, 0, 0, 0, 0);
        step(1, 32'd6, 1, 1, 0, 32'h11, 0);
        first_fgnt = -1;
        for (int c = 0; c < 6; c++) begin
            step(1, 32'h60, 0, 1, 0, 32'h12, 0);
            if (last_fgnt && first_fgnt < 0) first_fgnt = c;
        end
        chk("flush_restart", first_fgnt, 4);
        idle();

        // Async reset in the response cycle of a data read
        step(0, 0, 0, 1, 0, 32'h10, 0);
        @(posedge clk);
        #1;
        chk("pre_rst_d_rvalid", d_rvalid, 1'b1);
        chk("pre_rst_d_rdata", d_rdata, m_data);
        d_req = 1; d_we = 1; d_addr = 32'h33; d_wdata = 32'hBAD;
        nrst = 1'b0;
        #1;
        chk("mid_rst_d_rvalid", d_rvalid, 1'b0);
        chk("mid_rst_f_rvalid", f_rvalid, 1'b0);
        chk("mid_rst_mem_wen", mem_wen, 1'b0);
        m_owner = 0; m_wait = 0;
        @(negedge clk);
        d_req = 0; d_we = 0;
        nrst = 1'b1;
        idle();
        idle();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 31), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, $urandom_range(0, 31),
                 $urandom);
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
